// File: rtl/bist_pkg.sv
// Shared BIST types, default LFSR constants and the LFSR step function.
package bist_pkg;

  localparam int unsigned TPG_WIDTH = 8;
  localparam int unsigned TPG_CNT_W = 8;

  localparam logic [TPG_WIDTH-1:0] TPG_TAPS = 8'hB8;
  localparam logic [TPG_WIDTH-1:0] TPG_SEED = 8'h01;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FLUSH,
    CHECK,
    DONE
  } tpg_state_e;

  // Fibonacci step: feedback is the parity of the tapped bits, shifted in at bit 0.
  function automatic logic [TPG_WIDTH-1:0] lfsr_next(input logic [TPG_WIDTH-1:0] state,
                                                     input logic [TPG_WIDTH-1:0] taps);
    return {state[TPG_WIDTH-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Load/step-enable LFSR register; an all-zero seed is replaced by 1 so the register never locks up.
import bist_pkg::*;

module bist_lfsr #(
  parameter int unsigned          WIDTH = TPG_WIDTH,
  parameter logic [WIDTH-1:0]     TAPS  = TPG_TAPS,
  parameter logic [WIDTH-1:0]     SEED  = TPG_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED_EFF;
    end else if (load) begin
      q <= SEED_EFF;
    end else if (step) begin
      q <= WIDTH'(lfsr_next(TPG_WIDTH'(q), TPG_WIDTH'(TAPS)));
    end
  end

endmodule

// File: rtl/bist_tpg.sv
// BIST pattern generator and run controller: LFSR stimulus, compactor clear, golden compare.
// Optional feature macro: BIST_TPG_ABORT_EN adds an abort input that cancels LOAD/RUN/FLUSH.
import bist_pkg::*;

module bist_tpg #(
  parameter int unsigned      WIDTH        = TPG_WIDTH,
  parameter logic [WIDTH-1:0] TAPS         = TPG_TAPS,
  parameter logic [WIDTH-1:0] SEED         = TPG_SEED,
  parameter int unsigned      NUM_PATTERNS = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef BIST_TPG_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] signature,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] pattern,
  output logic             pattern_valid,
  output logic             misr_clr,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [TPG_CNT_W-1:0] LAST_CNT = TPG_CNT_W'(NUM_PATTERNS - 1);

  tpg_state_e           state;
  tpg_state_e           state_next;
  logic [TPG_CNT_W-1:0] count;
  logic                 lfsr_load;
  logic                 lfsr_step;
  logic                 abort_c;

`ifdef BIST_TPG_ABORT_EN
  assign abort_c = abort && ((state == LOAD) || (state == RUN) || (state == FLUSH));
`else
  assign abort_c = 1'b0;
`endif

  bist_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .q    (pattern)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and LFSR control; abort overrides every other transition.
  always_comb begin
    state_next = state;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          lfsr_load  = 1'b1;
        end
      end
      LOAD:  state_next = RUN;
      RUN: begin
        lfsr_step = 1'b1;
        if (count == LAST_CNT) begin
          state_next = FLUSH;
        end
      end
      FLUSH: state_next = CHECK;
      CHECK: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_c) begin
      state_next = IDLE;
      lfsr_step  = 1'b0;
    end
  end

  // Pattern counter, registered state decodes and sticky pass flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count         <= '0;
      pattern_valid <= 1'b0;
      misr_clr      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      if (state == LOAD) begin
        count <= '0;
      end else if (state == RUN) begin
        count <= count + TPG_CNT_W'(1);
      end
      pattern_valid <= (state_next == RUN);
      misr_clr      <= (state_next == LOAD);
      busy          <= (state_next != IDLE);
      done          <= (state_next == DONE);
      if (lfsr_load || abort_c) begin
        pass <= 1'b0;
      end else if (state == CHECK) begin
        pass <= (signature == golden);
      end
    end
  end

endmodule

// File: tb/tb_bist_tpg.sv
// Directed/randomized bench for bist_tpg with a behavioural pattern and signature model.
module tb_bist_tpg;

  localparam int unsigned N = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] signature;
  logic [7:0] golden;
  logic [7:0] pattern;
  logic       pattern_valid;
  logic       misr_clr;
  logic       busy;
  logic       done;
  logic       pass;
`ifdef BIST_TPG_ABORT_EN
  logic       abort;
`endif

  always #5 clk = ~clk;

  bist_tpg dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
`ifdef BIST_TPG_ABORT_EN
    .abort         (abort),
`endif
    .signature     (signature),
    .golden        (golden),
    .pattern       (pattern),
    .pattern_valid (pattern_valid),
    .misr_clr      (misr_clr),
    .busy          (busy),
    .done          (done),
    .pass          (pass)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] mulc;
  logic [7:0] xmask;
  logic [7:0] ref_seq [N];
  logic [7:0] ref_sig;
  logic [7:0] obs_pat [N];
  int         cyc;
  int         first_valid;
  int         n_valid;
  int         n_clr;
  int         done_cyc;
  logic       pass_at_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] p);
    int ones;
    ones = $countones(p & 8'hB8);
    return {p[6:0], 1'(ones % 2)};
  endfunction

  function automatic logic [7:0] cut(input logic [7:0] p);
    return 8'(p * mulc) ^ xmask;
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] r);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ r;
  endfunction

  // Compactor stand-in: clears on misr_clr, folds in the CUT response of each valid pattern.
  always @(posedge clk or negedge rst) begin
    if (!rst) signature <= 8'h00;
    else if (misr_clr) signature <= 8'h00;
    else if (pattern_valid) signature <= misr_step(signature, cut(pattern));
  end

  task automatic build_model();
    ref_seq[0] = 8'h01;
    for (int k = 1; k < N; k++) ref_seq[k] = ref_step(ref_seq[k-1]);
    ref_sig = 8'h00;
    for (int k = 0; k < N; k++) ref_sig = misr_step(ref_sig, cut(ref_seq[k]));
  endtask

  // Start a run at the next edge and watch until done (bounded); cycle 1 is LOAD.
  task automatic observe(input int pulse_cyc, input bit hold);
    first_valid = 0; n_valid = 0; n_clr = 0; done_cyc = 0; pass_at_done = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = hold; cyc = 1;
    while (done_cyc == 0 && cyc < int'(N) + 20) begin
      if (misr_clr) n_clr++;
      if (pattern_valid) begin
        if (first_valid == 0) first_valid = cyc;
        if (n_valid < int'(N)) obs_pat[n_valid] = pattern;
        n_valid++;
      end
      if (done) begin
        done_cyc = cyc;
        pass_at_done = pass;
      end else begin
        if (!hold) start = (cyc == pulse_cyc);
        @(negedge clk); cyc++;
      end
    end
  endtask

  task automatic check_run(input logic exp_pass);
    int mism;
    mism = 0;
    for (int k = 0; k < int'(N) && k < n_valid; k++)
      if (obs_pat[k] !== ref_seq[k]) mism++;
    chk("first_valid_cycle", 32'(first_valid), 32'd2);
    chk("valid_count", 32'(n_valid), 32'(N));
    chk("misr_clr_count", 32'(n_clr), 32'd1);
    chk("done_cycle", 32'(done_cyc), 32'(N + 4));
    chk("pattern_seq_mismatches", 32'(mism), 32'd0);
    chk("pass_at_done", 32'(pass_at_done), 32'(exp_pass));
  endtask

  initial begin
    int   distinct;
    bit   seen [256];
    int   seen_done;
    int   extra_clr;
    logic p2;

    mulc  = 8'($urandom_range(255, 0)) | 8'h01;
    xmask = 8'($urandom_range(255, 0));
    build_model();
    rst = 1'b0; start = 1'b0; golden = 8'h00;
`ifdef BIST_TPG_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_pattern", 32'(pattern), 32'h01);
    chk("rst_pattern_valid", 32'(pattern_valid), 32'd0);
    chk("rst_misr_clr", 32'(misr_clr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Run 1: golden matches model signature; full-period coverage.
    golden = ref_sig;
    observe(0, 1'b0);
    check_run(1'b1);
    chk("first_patterns", {obs_pat[1], obs_pat[2], obs_pat[3], obs_pat[4]}, 32'h02040811);
    foreach (seen[i]) seen[i] = 1'b0;
    for (int k = 0; k < int'(N); k++) seen[obs_pat[k]] = 1'b1;
    distinct = 0;
    for (int i = 1; i < 256; i++) if (seen[i]) distinct++;
    chk("distinct_nonzero", 32'(distinct), 32'd255);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("pattern_wraps_to_seed", 32'(pattern), 32'h01);
    repeat (5) @(negedge clk);
    chk("pass_sticky", 32'(pass), 32'd1);

    // Run 2: one golden bit flipped.
    golden = ref_sig ^ 8'(1 << $urandom_range(7, 0));
    observe(0, 1'b0);
    check_run(1'b0);

    // Run 3: start pulsed mid-RUN is ignored.
    golden = ref_sig;
    observe(int'($urandom_range(40, 3)), 1'b0);
    check_run(1'b1);
    repeat (3) @(negedge clk);
    chk("no_restart_busy", 32'(busy), 32'd0);

    // Run 4: start held high gives back-to-back runs.
    observe(0, 1'b1);
    check_run(1'b1);
    @(negedge clk);
    chk("b2b_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("b2b_second_load", 32'(misr_clr), 32'd1);
    start = 1'b0;
    seen_done = 0; extra_clr = 0; p2 = 1'b0;
    for (int i = 0; i < int'(N) + 20 && seen_done == 0; i++) begin
      @(negedge clk);
      if (misr_clr) extra_clr++;
      if (done) begin seen_done = 1; p2 = pass; end
    end
    chk("b2b_second_done", 32'(seen_done), 32'd1);
    chk("b2b_extra_misr_clr", 32'(extra_clr), 32'd0);
    chk("b2b_second_pass", 32'(p2), 32'd1);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (int'($urandom_range(60, 10))) @(negedge clk);
    chk("pre_reset_valid", 32'(pattern_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pattern", 32'(pattern), 32'h01);
    chk("async_rst_valid", 32'(pattern_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_pass", 32'(pass), 32'd0);
    @(negedge clk); rst = 1'b1;
    seen_done = 0;
    for (int i = 0; i < int'(N) + 20; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    chk("no_done_after_reset", 32'(seen_done), 32'd0);

`ifdef BIST_TPG_ABORT_EN
    // Abort in RUN cycle 5 after a passing run.
    golden = ref_sig;
    observe(0, 1'b0);
    chk("abort_prerun_pass", 32'(pass_at_done), 32'd1);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_in_run", 32'(pattern_valid), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(pattern_valid), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    seen_done = 0;
    for (int i = 0; i < int'(N) + 20; i++) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
